// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and arbiter state encoding
package uart_pkg;

    localparam int DEFAULT_DATA_BITS = 8;

    typedef enum logic [1:0] {
        ARB_IDLE      = 2'd0,
        ARB_LAUNCH    = 2'd1,
        ARB_WAIT_BUSY = 2'd2,
        ARB_ACTIVE    = 2'd3
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin winner search starting at ptr
module rr_pick #(
    parameter int N = 4,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] winner,
    output logic          found
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [PW-1:0]  offset;
    logic [PW:0]    sum;

    always_comb begin
        dbl    = {req, req};
        rot    = N'(dbl >> ptr);
        found  = |rot;
        offset = '0;
        // Descending scan so the lowest set bit (closest to ptr) wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                offset = PW'(i);
            end
        end
        sum = {1'b0, ptr} + {1'b0, offset};
        if (sum >= (PW + 1)'(N)) begin
            sum = sum - (PW + 1)'(N);
        end
        winner = sum[PW-1:0];
    end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1-style serializer: start bit, LSB-first data, stop bit
module uart_tx #(
    parameter int DATA_BITS    = uart_pkg::DEFAULT_DATA_BITS,
    parameter int CLKS_PER_BIT = 4,
    localparam int CW = $clog2(CLKS_PER_BIT),
    localparam int BW = $clog2(DATA_BITS + 2)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_busy,
    output logic                 tx_line
);

    logic [DATA_BITS:0] shreg_q, shreg_d;
    logic [BW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]      clk_cnt_q, clk_cnt_d;
    logic               busy_q, busy_d;
    logic               line_q, line_d;

    always_comb begin
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        clk_cnt_d = clk_cnt_q;
        busy_d    = busy_q;
        line_d    = line_q;
        if (!busy_q) begin
            if (tx_start) begin
                shreg_d   = {1'b1, tx_data};
                bit_cnt_d = '0;
                clk_cnt_d = '0;
                busy_d    = 1'b1;
                line_d    = 1'b0;
            end
        end else if (clk_cnt_q == CW'(CLKS_PER_BIT - 1)) begin
            clk_cnt_d = '0;
            // bit_cnt_q is the index of the bit currently on the line.
            if (bit_cnt_q == BW'(DATA_BITS + 1)) begin
                busy_d = 1'b0;
                line_d = 1'b1;
            end else begin
                line_d    = shreg_q[0];
                shreg_d   = shreg_q >> 1;
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end else begin
            clk_cnt_d = clk_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            clk_cnt_q <= '0;
            busy_q    <= 1'b0;
            line_q    <= 1'b1;
        end else begin
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            clk_cnt_q <= clk_cnt_d;
            busy_q    <= busy_d;
            line_q    <= line_d;
        end
    end

    assign tx_busy = busy_q;
    assign tx_line = line_q;

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin scheduler sharing one uart_tx among NUM_REQ producers
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_BITS = DEFAULT_DATA_BITS,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
    input  logic [NUM_REQ-1:0]           req_lock,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         tx_start,
    output logic [DATA_BITS-1:0]         tx_data,
    input  logic                         tx_busy,
    output logic [IW-1:0]                grant_id,
    output logic                         arb_busy
);

    arb_state_e           state_q, state_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
    logic                 tx_start_q, tx_start_d;
    logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
    logic [IW-1:0]        grant_id_q, grant_id_d;
    logic                 arb_busy_q, arb_busy_d;

    logic [IW-1:0]        win;
    logic                 found;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req    (req_valid),
        .ptr    (ptr_q),
        .winner (win),
        .found  (found)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        req_ready_d = '0;
        tx_start_d  = 1'b0;
        tx_data_d   = tx_data_q;
        grant_id_d  = grant_id_q;
        arb_busy_d  = arb_busy_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (found) begin
                    tx_start_d  = 1'b1;
                    tx_data_d   = req_data[int'(win)*DATA_BITS +: DATA_BITS];
                    req_ready_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
                    grant_id_d  = win;
                    arb_busy_d  = 1'b1;
                    // A locked owner keeps the pointer so it wins the next search if still valid.
                    if (req_lock[win]) begin
                        ptr_d = win;
                    end else if (win == IW'(NUM_REQ - 1)) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = win + 1'b1;
                    end
                    state_d = ARB_LAUNCH;
                end
            end
            ARB_LAUNCH: begin
                state_d = ARB_WAIT_BUSY;
            end
            ARB_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = ARB_ACTIVE;
                end
            end
            ARB_ACTIVE: begin
                if (!tx_busy) begin
                    arb_busy_d = 1'b0;
                    state_d    = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ARB_IDLE;
            ptr_q       <= '0;
            req_ready_q <= '0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= '0;
            grant_id_q  <= '0;
            arb_busy_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            req_ready_q <= req_ready_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            grant_id_q  <= grant_id_d;
            arb_busy_q  <= arb_busy_d;
        end
    end

    assign req_ready = req_ready_q;
    assign tx_start  = tx_start_q;
    assign tx_data   = tx_data_q;
    assign grant_id  = grant_id_q;
    assign arb_busy  = arb_busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter driving uart_tx
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int DB  = 8;
    localparam int CPB = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [N-1:0]  req_valid;
    logic [N*DB-1:0] req_data;
    logic [N-1:0]  req_lock;
    logic [N-1:0]  req_ready;
    logic          tx_start;
    logic [DB-1:0] tx_data;
    logic          tx_busy;
    logic [1:0]    grant_id;
    logic          arb_busy;
    logic          tx_line;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(N), .DATA_BITS(DB)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_lock  (req_lock),
        .req_ready (req_ready),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_busy   (tx_busy),
        .grant_id  (grant_id),
        .arb_busy  (arb_busy)
    );

    uart_tx #(.DATA_BITS(DB), .CLKS_PER_BIT(CPB)) u_tx (
        .clk      (clk),
        .reset_n  (reset_n),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .tx_line  (tx_line)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_start(input string tag, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!tx_start && n < 300);
        if (!tx_start) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_busy(input logic val, input string tag);
        int n = 0;
        while (tx_busy !== val && n < 300) begin
            tick();
            n++;
        end
        if (tx_busy !== val) chk({tag, "_timeout"}, 32'(tx_busy), 32'(val));
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (arb_busy !== 1'b0 && n < 300) begin
            tick();
            n++;
        end
        if (arb_busy !== 1'b0) chk({tag, "_timeout"}, 32'(arb_busy), 32'd0);
    endtask

    initial begin
        int         n;
        logic [7:0] rr_data [5];
        logic [1:0] rr_id   [5];
        logic [1:0] lk_id   [5];
        logic [7:0] lk_data [5];
        logic [7:0] line_byte;
        logic       start_bit, stop_bit, early_ready;

        rr_data = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
        rr_id   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        lk_id   = '{2'd1, 2'd1, 2'd1, 2'd3, 2'd0};
        lk_data = '{8'h31, 8'h32, 8'h33, 8'h43, 8'h40};

        // Reset held with every requester valid
        reset_n   = 1'b0;
        req_valid = 4'b1111;
        req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        req_lock  = 4'b0000;
        repeat (3) tick();
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_tx_start", 32'(tx_start), 32'd0);
        chk("reset_tx_data", 32'(tx_data), 32'd0);
        chk("reset_grant_id", 32'(grant_id), 32'd0);
        chk("reset_arb_busy", 32'(arb_busy), 32'd0);
        reset_n = 1'b1;

        // Round-robin with all four valid
        for (int k = 0; k < 5; k++) begin
            wait_start("rr_wait", n);
            if (k == 0) chk("rr_first_latency", 32'(n), 32'd1);
            chk("rr_tx_data", 32'(tx_data), 32'(rr_data[k]));
            chk("rr_grant_id", 32'(grant_id), 32'(rr_id[k]));
            chk("rr_req_ready", 32'(req_ready), 32'(4'b0001 << rr_id[k]));
            if (k == 4) req_valid = 4'b0000;
            tick();
            chk("rr_start_one_cycle", 32'(tx_start), 32'd0);
        end
        wait_idle("rr_idle");

        // Lock: requester 1 sends three bytes back-to-back, then 3, then 0
        req_data  = {8'h43, 8'h00, 8'h31, 8'h40};
        req_valid = 4'b1011;
        req_lock  = 4'b0010;
        for (int k = 0; k < 5; k++) begin
            wait_start("lock_wait", n);
            chk("lock_grant_id", 32'(grant_id), 32'(lk_id[k]));
            chk("lock_tx_data", 32'(tx_data), 32'(lk_data[k]));
            case (k)
                0: req_data[15:8] = 8'h32;
                1: req_data[15:8] = 8'h33;
                2: begin req_valid[1] = 1'b0; req_lock = 4'b0000; end
                3: req_valid[3] = 1'b0;
                default: req_valid[0] = 1'b0;
            endcase
        end
        wait_idle("lock_idle");

        // Single request from requester 2 and its serial frame
        req_data[23:16] = 8'hA5;
        req_valid       = 4'b0100;
        tick();
        chk("single_req_ready", 32'(req_ready), 32'h4);
        chk("single_tx_start", 32'(tx_start), 32'd1);
        chk("single_tx_data", 32'(tx_data), 32'hA5);
        chk("single_grant_id", 32'(grant_id), 32'd2);
        chk("single_arb_busy", 32'(arb_busy), 32'd1);
        req_valid = 4'b0000;
        tick();
        chk("single_start_drop", 32'(tx_start), 32'd0);
        chk("single_ready_drop", 32'(req_ready), 32'd0);
        n = 0;
        while (tx_line !== 1'b0 && n < 20) begin
            tick();
            n++;
        end
        repeat (CPB / 2) tick();
        start_bit = tx_line;
        for (int i = 0; i < DB; i++) begin
            repeat (CPB) tick();
            line_byte[i] = tx_line;
        end
        repeat (CPB) tick();
        stop_bit = tx_line;
        chk("line_start_bit", 32'(start_bit), 32'd0);
        chk("line_byte", 32'(line_byte), 32'hA5);
        chk("line_stop_bit", 32'(stop_bit), 32'd1);
        wait_busy(1'b0, "single_busy_fall");
        chk("single_arb_busy_hold", 32'(arb_busy), 32'd1);
        tick();
        chk("single_arb_busy_fall", 32'(arb_busy), 32'd0);

        // Late arrival of requester 3 during ACTIVE
        req_valid = 4'b0001;
        wait_start("late_first", n);
        chk("late_first_grant", 32'(grant_id), 32'd0);
        req_valid = 4'b0000;
        wait_busy(1'b1, "late_busy_rise");
        repeat (3) tick();
        req_valid[3]    = 1'b1;
        req_data[31:24] = 8'h5A;
        early_ready     = 1'b0;
        n = 0;
        while (tx_busy === 1'b1 && n < 300) begin
            if (req_ready != 4'b0000 || tx_start) early_ready = 1'b1;
            tick();
            n++;
        end
        chk("late_busy_fall_seen", 32'(tx_busy), 32'd0);
        chk("late_no_early_ready", 32'(early_ready | (|req_ready)), 32'd0);
        tick();
        chk("late_e1_tx_start", 32'(tx_start), 32'd0);
        chk("late_e1_arb_busy", 32'(arb_busy), 32'd0);
        tick();
        chk("late_e2_tx_start", 32'(tx_start), 32'd1);
        chk("late_e2_req_ready", 32'(req_ready), 32'h8);
        chk("late_e2_tx_data", 32'(tx_data), 32'h5A);
        chk("late_e2_grant_id", 32'(grant_id), 32'd3);
        req_valid = 4'b0000;
        wait_idle("late_idle");

        // Reset mid-frame while the pointer sits at 2
        req_data[15:8] = 8'h77;
        req_valid      = 4'b0010;
        wait_start("mid_first", n);
        chk("mid_first_grant", 32'(grant_id), 32'd1);
        req_valid = 4'b0000;
        wait_busy(1'b1, "mid_busy_rise");
        repeat (3) tick();
        chk("mid_arb_busy_before", 32'(arb_busy), 32'd1);
        reset_n = 1'b0;
        #2;
        chk("mid_rst_arb_busy", 32'(arb_busy), 32'd0);
        chk("mid_rst_grant_id", 32'(grant_id), 32'd0);
        chk("mid_rst_tx_data", 32'(tx_data), 32'd0);
        chk("mid_rst_outputs", 32'({req_ready, tx_start}), 32'd0);
        chk("mid_rst_tx_busy", 32'(tx_busy), 32'd0);
        tick();
        reset_n   = 1'b1;
        req_valid = 4'b1110;
        wait_start("post_rst", n);
        chk("post_rst_latency", 32'(n), 32'd1);
        chk("post_rst_grant", 32'(grant_id), 32'd1);
        req_valid = 4'b0000;
        wait_idle("post_rst_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
